seq_pattern_detector: RTL and testbench
=======================================

# seq_pattern_detector

Parametrised serial bit-pattern detector. It is the generalised successor of the fixed "101" detector FSM: configurable pattern width, a pattern that can be reloaded at run time, overlapping or non-overlapping match mode, a bit-valid qualifier, and a saturating match counter. It sits on a single-bit serial input stream and drives a one-cycle match strobe plus a match count to downstream control logic.

## Interface
- PAT_W, 3: pattern length in bits; legal range 2..32.
- PATTERN, 3'b101: pattern held after reset; the MSB is matched against the oldest bit.
- CNT_W, 8: width of the match counter.

- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  bit-valid; x is sampled only when en=1.
- x  input  1  serial data bit.
- overlap  input  1  1 = overlapping matches allowed; 0 = a match consumes its bits. Quasi-static.
- pat_load  input  1  loads pat_in into the pattern register.
- pat_in  input  PAT_W  new pattern value.
- clr_cnt  input  1  synchronous clear of match_cnt.
- match  output  1  registered one-cycle strobe.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  high while match_cnt is all-ones.

## Operation
- State registers:
  - hist[PAT_W-1:0]: shift register of received bits.
  - fill: number of valid bits in hist, 0..PAT_W, saturating.
  - pat_q: current pattern.
- Two-state control per bit: FILLING (fill<PAT_W) and ARMED (fill==PAT_W).
- Accepted bit (en=1, pat_load=0):
  - hist_n = {hist[PAT_W-2:0], x}.
  - fill_n = min(fill+1, PAT_W).
  - A hit occurs when fill_n==PAT_W and hist_n==pat_q.
- On a hit:
  - match<=1 and match_cnt increments, unless it is saturated.
  - If overlap=0, fill<=0, so the next match needs PAT_W new bits. hist keeps its contents but they are ignored.
  - If overlap=1, fill stays at PAT_W.
- en=0: hist, fill and the counter hold; match<=0.
- pat_load=1:
  - pat_q<=pat_in, fill<=0, match<=0.
  - It has priority over en, so a bit presented in the same cycle is dropped.
  - match_cnt is unaffected.
- clr_cnt=1: match_cnt<=0. If a hit occurs in the same cycle, the clear wins (count 0), but match still pulses.
- Counter arithmetic: unsigned, CNT_W bits, saturates at 2^CNT_W-1 with no wrap. cnt_sat = &match_cnt.

## Timing
- Reset values:
  - hist=0, fill=0, pat_q=PATTERN.
  - match=0, match_cnt=0, cnt_sat=0.
- Latency:
  - match rises in the cycle after the rising edge that samples the final pattern bit. This is Moore-equivalent: registered, with no combinational path from x to match.
  - match_cnt updates on the same edge as match.
- match is high for exactly one cycle per hit.
- In overlap mode, consecutive hits may give back-to-back match pulses; for example, pattern 111 with input 1111 gives pulses on bits 3 and 4.
- Reset mid-stream discards partial history, so a partial pattern spanning a reset never matches.
- Changing overlap during a stream takes effect at the next hit.
- Back-to-back pat_load is allowed; the last value wins.

## Structure
- Shared package `pattern_det_pkg`:
  - Localparams for the legal PAT_W bounds.
  - A typedef for the fill-state enum (FILLING, ARMED).
  - A default CNT_W constant.
- Sub-module `sat_counter` (parameter W; inputs inc and clr with clr priority; outputs cnt and sat). It is instantiated once for match_cnt.
- Elaboration-time check that PAT_W is within 2..32.

## Test plan
- PAT_W=3, PATTERN=101, overlap=1, en=1, x stream 1,0,1,0,1:
  - match pulses one cycle after bits 3 and 5.
  - match_cnt=2 at the end.
- Same stream with overlap=0:
  - a single match after bit 3, none after bit 5, match_cnt=1.
  - Stream 1,0,1,1,0,1 then gives matches after bits 3 and 6.
- en gaps: x=1 (en=1), then two cycles with en=0 and x=0, then 0,1 (en=1):
  - match after the final bit.
  - match stays 0 during the gap cycles.
- Runtime reload: pat_load with pat_in=3'b011 while 1,0 is partially received, then stream 0,1,1:
  - match after the final 1.
  - The old 101 is no longer detected.
- Saturation and clear with CNT_W=2 and five hits:
  - match_cnt=3, cnt_sat=1.
  - clr_cnt asserted coincident with a hit gives match_cnt=0 and a match pulse.
- Reset mid-operation: bits 1,0, then rst_n low for 1 cycle asynchronously, then bit 1:
  - no match.
  - All outputs are 0 while rst_n is low.
  - The bench then sends 0,1 and sees a match after it.

Source files
------------

// File: rtl/pattern_det_pkg.sv
// Purpose : shared constants and types for the serial pattern detector.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package pattern_det_pkg;

    // Legal pattern lengths; a 1-bit pattern is a plain equality test and
    // anything past 32 bits no longer fits the history compare cheaply.
    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;

    // Default width of the saturating match counter.
    localparam int CNT_W_DEF = 8;

    // Per-bit control state: FILLING until PAT_W bits of the current window
    // have been collected, ARMED once every new bit can complete a match.
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } fill_state_e;

    // Bits needed to hold a fill count in the range 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage : pattern_det_pkg

// File: rtl/sat_counter.sv
// Purpose : unsigned up-counter that sticks at all-ones; clear beats increment.
// Latency : cnt/sat update on the clock edge that samples inc/clr.
// Backpressure: none; inc is ignored while saturated, never wraps.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear, wins over inc
//   cnt        : current count
//   sat        : high while cnt is all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         full;

    assign full = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !full) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = full;

endmodule : sat_counter

// File: rtl/seq_pattern_detector.sv
// Purpose : serial bit-pattern detector with reloadable pattern, overlap
//           control, bit-valid qualifier and saturating match counter.
// Latency : match/match_cnt update on the edge that samples the final
//           pattern bit (registered, no combinational x->match path).
// Backpressure: none; en qualifies bits, en=0 simply holds state.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en, x      : bit-valid and serial data bit
//   overlap    : 1 = matches may share bits, 0 = a match consumes its bits
//   pat_load   : load pat_in as the new pattern (drops any bit this cycle)
//   pat_in     : new pattern, MSB compared with the oldest bit
//   clr_cnt    : clear match_cnt (wins over a same-cycle hit)
//   match      : one-cycle strobe per hit
//   match_cnt  : saturating hit count
//   cnt_sat    : match_cnt is all-ones
module seq_pattern_detector
    import pattern_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("seq_pattern_detector: PAT_W=%0d outside legal range %0d..%0d",
               PAT_W, PAT_W_MIN, PAT_W_MAX);
    end

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_pattern_detector: CNT_W=%0d must be at least 1", CNT_W);
    end

    localparam int                FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic              match_q, match_d;
    fill_state_e       state_q, state_d;

    // Candidate values for an accepted bit.
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        match_d = 1'b0;
        hit     = 1'b0;

        // Newest bit enters at the LSB; the cast drops the oldest bit so the
        // MSB of the window lines up with the MSB of the pattern.
        hist_shift = PAT_W'({hist_q, x});

        // Once ARMED the window is already full, so fill just stays put.
        fill_inc = (state_q == ARMED) ? FILL_FULL : (fill_q + 1'b1);

        if (pat_load) begin
            // A new pattern invalidates whatever is in the window; the bit
            // on x this cycle is deliberately discarded.
            pat_d  = pat_in;
            fill_d = '0;
        end else if (en) begin
            hist_d  = hist_shift;
            hit     = (fill_inc == FILL_FULL) && (hist_shift == pat_q);
            match_d = hit;
            // Non-overlap: restart filling so the next match needs a full
            // set of fresh bits. hist keeps its stale contents; fill masks
            // them until they have all been shifted out.
            if (hit && !overlap) begin
                fill_d = '0;
            end else begin
                fill_d = fill_inc;
            end
        end

        state_d = (fill_d == FILL_FULL) ? ARMED : FILLING;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN;
            match_q <= 1'b0;
            state_q <= FILLING;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            match_q <= match_d;
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Match counter
    // ------------------------------------------------------------------
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (clr_cnt),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

    assign match = match_q;

endmodule : seq_pattern_detector

// File: tb/tb_seq_pattern_detector.sv
// Purpose : directed + randomized bench for seq_pattern_detector, two
//           instances (CNT_W=8 and CNT_W=2) sharing all inputs.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_seq_pattern_detector;

    localparam int         PAT_W   = 3;
    localparam logic [2:0] PATTERN = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       x;
    logic       overlap;
    logic       pat_load;
    logic [2:0] pat_in;
    logic       clr_cnt;

    logic       match_a, sat_a;
    logic [7:0] cnt_a;
    logic       match_b, sat_b;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    seq_pattern_detector #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .CNT_W   (8)
    ) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .x         (x),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .clr_cnt   (clr_cnt),
        .match     (match_a),
        .match_cnt (cnt_a),
        .cnt_sat   (sat_a)
    );

    seq_pattern_detector #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .CNT_W   (2)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .x         (x),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .clr_cnt   (clr_cnt),
        .match     (match_b),
        .match_cnt (cnt_b),
        .cnt_sat   (sat_b)
    );

    // Reference model: the bits of the current match window are kept in a
    // queue; a hit is "the last PAT_W accepted bits spell the pattern".
    bit         mq[$];
    logic [2:0] m_pat;
    bit         m_match;
    int         m_cnt_a;
    int         m_cnt_b;

    int n_checks;
    int n_pass;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pat   = PATTERN;
        m_match = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic model_step();
        bit         hit;
        logic [2:0] win;
        hit = 1'b0;
        if (pat_load) begin
            m_pat = pat_in;
            mq.delete();
        end else if (en) begin
            mq.push_back(x);
            if (mq.size() > PAT_W) void'(mq.pop_front());
            if (mq.size() == PAT_W) begin
                win = '0;
                foreach (mq[i]) win = {win[1:0], mq[i]};
                if (win == m_pat) begin
                    hit = 1'b1;
                    if (!overlap) mq.delete();
                end
            end
        end
        m_match = hit;
        if (clr_cnt) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (hit) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3)   m_cnt_b++;
        end
    endtask

    task automatic check_all();
        chk("match_a", match_a, m_match);
        chk("match_b", match_b, m_match);
        chk("cnt_a",   cnt_a,   m_cnt_a);
        chk("cnt_b",   cnt_b,   m_cnt_b);
        chk("sat_a",   sat_a,   m_cnt_a == 255);
        chk("sat_b",   sat_b,   m_cnt_b == 3);
    endtask

    task automatic cycle(input logic e, input logic b);
        en = e;
        x  = b;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // bits[0] is sent first; seen[i] is match right after bit i.
    task automatic run_bits(input logic [15:0] bits, input int n, output logic [15:0] seen);
        seen = '0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, bits[i]);
            seen[i] = match_a;
        end
    endtask

    // Asserts reset between clock edges, checks outputs while it is held.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_match_a", match_a, 0);
        chk("rst_cnt_a",   cnt_a,   0);
        chk("rst_sat_a",   sat_a,   0);
        chk("rst_match_b", match_b, 0);
        chk("rst_cnt_b",   cnt_b,   0);
        chk("rst_sat_b",   sat_b,   0);
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] seen;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        x        = 1'b0;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_in   = '0;
        clr_cnt  = 1'b0;
        model_reset();

        // Overlap: 1,0,1,0,1 -> hits after bits 3 and 5.
        async_reset();
        overlap = 1'b1;
        run_bits(16'b10101, 5, seen);
        chk("ovl_pulses", seen[4:0], 5'b10100);
        chk("ovl_cnt",    cnt_a,     2);

        // Non-overlap: same stream -> only bit 3.
        async_reset();
        overlap = 1'b0;
        run_bits(16'b10101, 5, seen);
        chk("novl_pulses", seen[4:0], 5'b00100);
        chk("novl_cnt",    cnt_a,     1);

        // Non-overlap: 1,0,1,1,0,1 -> bits 3 and 6.
        async_reset();
        run_bits(16'b101101, 6, seen);
        chk("novl2_pulses", seen[5:0], 6'b100100);
        chk("novl2_cnt",    cnt_a,     2);

        // en gaps hold the partial window.
        async_reset();
        overlap = 1'b1;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        chk("gap1_match", match_a, 0);
        cycle(1'b0, 1'b0);
        chk("gap2_match", match_a, 0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        chk("gap_final_match", match_a, 1);

        // Reload mid-window, bit during load is dropped.
        async_reset();
        run_bits(16'b01, 2, seen);
        pat_load = 1'b1;
        pat_in   = 3'b011;
        cycle(1'b1, 1'b1);
        pat_load = 1'b0;
        run_bits(16'b110, 3, seen);
        chk("reload_pulses", seen[2:0], 3'b100);
        run_bits(16'b101, 3, seen);
        chk("reload_old_gone", seen[2:0], 3'b000);

        // Saturation: five hits, CNT_W=2 sticks at 3.
        async_reset();
        run_bits(16'b101_0101_0101, 11, seen);
        chk("sat_cnt_a", cnt_a, 5);
        chk("sat_cnt_b", cnt_b, 3);
        chk("sat_flag_b", sat_b, 1);
        chk("sat_flag_a", sat_a, 0);
        // Clear coincident with a hit: clear wins, strobe still fires.
        cycle(1'b1, 1'b0);
        clr_cnt = 1'b1;
        cycle(1'b1, 1'b1);
        clr_cnt = 1'b0;
        chk("clr_hit_match", match_a, 1);
        chk("clr_hit_cnt_a", cnt_a,   0);
        chk("clr_hit_cnt_b", cnt_b,   0);
        chk("clr_hit_sat_b", sat_b,   0);

        // Reset mid-stream discards the partial window.
        async_reset();
        run_bits(16'b01, 2, seen);
        async_reset();
        cycle(1'b1, 1'b1);
        chk("post_rst_no_match", match_a, 0);
        run_bits(16'b10, 2, seen);
        chk("post_rst_pulses", seen[1:0], 2'b10);

        // Randomized traffic against the model.
        async_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) overlap = ~overlap;
            pat_load = ($urandom_range(0, 29) == 0);
            pat_in   = 3'($urandom);
            clr_cnt  = ($urandom_range(0, 39) == 0);
            cycle($urandom_range(0, 3) != 0, 1'($urandom));
        end
        pat_load = 1'b0;
        clr_cnt  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seq_pattern_detector
